// File: rtl/dmem_access_master.sv
// Load/store initiator between the MEM stage and a word-addressed, async-read data memory.
// Optional: define DMEM_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses.
module dmem_access_master #(
  parameter int MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        resp_misaligned,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]  state_reg;
  logic        write_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] merged_reg;
  logic [31:0] rdata_reg;
  logic        fault_reg;
  logic        misaligned_reg;

  logic [4:0]  byte_shift;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic [31:0] merged_word;
  logic        out_of_range;
  logic        unsupported;
  logic        fault;
  logic        misaligned;
  logic        skip;
  logic        is_sw;

  assign byte_shift   = {addr_reg[1:0], 3'b000};
  assign out_of_range = {1'b0, addr_reg} >= 33'(MEM_BYTES);
  assign is_sw        = write_reg && (funct3_reg == 3'b010);

  always_comb begin
    if (write_reg) begin
      unsupported = (funct3_reg >= 3'b011);
    end else begin
      unsupported = (funct3_reg == 3'b011) || (funct3_reg == 3'b110) ||
                    (funct3_reg == 3'b111);
    end
  end

  assign fault = out_of_range || unsupported;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misaligned = ((funct3_reg[1:0] == 2'b01) && addr_reg[0]) ||
                      ((funct3_reg[1:0] == 2'b10) && (addr_reg[1:0] != 2'b00));
`else
  // Without the trap, the ignored low address bits simply select the lane.
  assign misaligned = 1'b0;
`endif

  assign skip = fault || misaligned;

  always_comb begin
    lane_byte   = mem_dout[byte_shift +: 8];
    lane_half   = addr_reg[1] ? mem_dout[31:16] : mem_dout[15:0];
    load_data   = 32'h0000_0000;
    merged_word = mem_dout;
    case (funct3_reg)
      3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b010:  load_data = mem_dout;
      3'b100:  load_data = {24'h00_0000, lane_byte};
      3'b101:  load_data = {16'h0000, lane_half};
      default: load_data = 32'h0000_0000;
    endcase
    if (funct3_reg[1:0] == 2'b00) begin
      merged_word[byte_shift +: 8] = wdata_reg[7:0];
    end else if (addr_reg[1]) begin
      merged_word[31:16] = wdata_reg[15:0];
    end else begin
      merged_word[15:0] = wdata_reg[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      write_reg      <= 1'b0;
      funct3_reg     <= 3'b000;
      addr_reg       <= 32'h0000_0000;
      wdata_reg      <= 32'h0000_0000;
      merged_reg     <= 32'h0000_0000;
      rdata_reg      <= 32'h0000_0000;
      fault_reg      <= 1'b0;
      misaligned_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            write_reg  <= req_write;
            funct3_reg <= req_funct3;
            addr_reg   <= req_addr;
            wdata_reg  <= req_wdata;
            state_reg  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          fault_reg      <= fault;
          misaligned_reg <= misaligned;
          rdata_reg      <= (skip || write_reg) ? 32'h0000_0000 : load_data;
          merged_reg     <= merged_word;
          // Sub-word stores need a second cycle to write the merged word back.
          if (!skip && write_reg && !is_sw) begin
            state_reg <= S_WRITE;
          end else begin
            state_reg <= S_RESP;
          end
        end
        S_WRITE: state_reg <= S_RESP;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign req_ready       = (state_reg == S_IDLE);
  assign resp_valid      = (state_reg == S_RESP);
  assign resp_rdata      = rdata_reg;
  assign resp_fault      = fault_reg;
  assign resp_misaligned = misaligned_reg;

  assign mem_addr  = {addr_reg[31:2], 2'b00};
  assign mem_read  = !reset && (state_reg == S_ACCESS) && !skip;
  assign mem_write = !reset && (((state_reg == S_ACCESS) && !skip && is_sw) ||
                                (state_reg == S_WRITE));

  always_comb begin
    if (state_reg == S_WRITE) begin
      mem_din = merged_reg;
    end else if ((state_reg == S_ACCESS) && !skip && is_sw) begin
      mem_din = wdata_reg;
    end else begin
      mem_din = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_dmem_access_master.sv
// Table-driven bench for dmem_access_master with a behavioural async-read memory.
`timescale 1ns/1ps
module tb_dmem_access_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        resp_misaligned;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  dmem_access_master #(.MEM_BYTES(65536)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .resp_misaligned(resp_misaligned),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read),
    .mem_write(mem_write), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  logic [31:0] tmem [0:16383];
  logic        pl_en;
  logic [13:0] pl_idx;
  logic [31:0] pl_val;

  assign mem_dout = tmem[mem_addr[15:2]];

  always @(posedge clk) begin
    if (pl_en) tmem[pl_idx] <= pl_val;
    else if (mem_write) tmem[mem_addr[15:2]] <= mem_din;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [13:0] idx, input logic [31:0] v);
    @(negedge clk);
    pl_idx = idx;
    pl_val = v;
    pl_en  = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  int          r_lat, r_nwr, r_nrd, r_wrc;
  logic [31:0] r_rd;
  logic        r_flt, r_mis;

  // Issue one request; k counts cycles after the accept edge, sampled on negedges.
  task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    r_lat = -1; r_nwr = 0; r_nrd = 0; r_wrc = -1;
    r_rd = 32'hxxxx_xxxx; r_flt = 1'bx; r_mis = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_write) begin r_nwr++; r_wrc = k; end
      if (mem_read) r_nrd++;
      if (resp_valid) begin
        r_lat = k; r_rd = resp_rdata; r_flt = resp_fault; r_mis = resp_misaligned;
        break;
      end
    end
  endtask

  typedef struct {
    logic        pl;
    logic [31:0] plv;
    logic        w;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        flt;
    logic        mis;
    int          lat;
    int          nwr;
    int          nrd;
    int          wrc;
    logic        cw;
    logic [31:0] word;
  } vec_t;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam logic [31:0] LH101_RD  = 32'h0000_0000;
  localparam logic        LH101_MIS = 1'b1;
  localparam int          LH101_NRD = 0;
`else
  localparam logic [31:0] LH101_RD  = 32'h0000_7F01;
  localparam logic        LH101_MIS = 1'b0;
  localparam int          LH101_NRD = 1;
`endif

  vec_t vecs [19];
  int   rr [1:6];
  int   rv [1:6];
  int   fl [1:6];

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h80FF7F01, 1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0, 2, 0, 1, -1, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0, 1'b0, 3'b100, 32'h103, 32'h0, 32'h00000080, 1'b0, 1'b0, 2, 0, 1, -1, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0, 1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF80FF, 1'b0, 1'b0, 2, 0, 1, -1, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h80FF7F01, 1'b0, 1'b0, 2, 0, 1, -1, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0, 1'b0, 3'b100, 32'h100, 32'h0, 32'h00000001, 1'b0, 1'b0, 2, 0, 1, -1, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0, 1'b0, 3'b000, 32'h101, 32'h0, 32'h0000007F, 1'b0, 1'b0, 2, 0, 1, -1, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0, 1'b0, 3'b101, 32'h102, 32'h0, 32'h000080FF, 1'b0, 1'b0, 2, 0, 1, -1, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0, 1'b0, 3'b001, 32'h100, 32'h0, 32'h00007F01, 1'b0, 1'b0, 2, 0, 1, -1, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h0, 1'b0, 3'b001, 32'h101, 32'h0, LH101_RD, 1'b0, LH101_MIS, 2, 0, LH101_NRD, -1, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 32'h11223344, 1'b1, 3'b000, 32'h102, 32'h000000AB, 32'h0, 1'b0, 1'b0, 3, 1, 1, 2, 1'b1, 32'h11AB3344};
    vecs[10] = '{1'b0, 32'h0, 1'b1, 3'b001, 32'h100, 32'h1234BEEF, 32'h0, 1'b0, 1'b0, 3, 1, 1, 2, 1'b1, 32'h11ABBEEF};
    vecs[11] = '{1'b0, 32'h0, 1'b1, 3'b000, 32'h103, 32'hFFFFFF55, 32'h0, 1'b0, 1'b0, 3, 1, 1, 2, 1'b1, 32'h55ABBEEF};
    vecs[12] = '{1'b0, 32'h0, 1'b1, 3'b010, 32'hFFFC, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 2, 1, 1, 1, 1'b1, 32'hDEADBEEF};
    vecs[13] = '{1'b0, 32'h0, 1'b1, 3'b010, 32'h10000, 32'h12345678, 32'h0, 1'b1, 1'b0, 2, 0, 0, -1, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 32'h0, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0, 2, 0, 0, -1, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 32'h0, 1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0, 2, 0, 0, -1, 1'b0, 32'h0};
    vecs[16] = '{1'b0, 32'h0, 1'b0, 3'b010, 32'h10000, 32'h0, 32'h0, 1'b1, 1'b0, 2, 0, 0, -1, 1'b0, 32'h0};
    vecs[17] = '{1'b0, 32'h0, 1'b1, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0, 2, 0, 0, -1, 1'b1, 32'h55ABBEEF};
    vecs[18] = '{1'b0, 32'h0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h55ABBEEF, 1'b0, 1'b0, 2, 0, 1, -1, 1'b0, 32'h0};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; pl_en = 1'b0; pl_idx = 14'h0; pl_val = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_fault", 32'(resp_fault), 32'h0);
    chk("rst_resp_misaligned", 32'(resp_misaligned), 32'h0);
    chk("rst_mem_read", 32'(mem_read), 32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_din", mem_din, 32'h0);

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].pl) preload(vecs[i].addr[15:2], vecs[i].plv);
      run_req(vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wd);
      $display("vec %0d w=%0b f3=%03b addr=%h wdata=%h -> lat=%0d rdata=%h fault=%0b mis=%0b writes=%0d reads=%0d",
               i, vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wd, r_lat, r_rd, r_flt, r_mis, r_nwr, r_nrd);
      chk($sformatf("vec%0d_latency", i), 32'(r_lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_rdata", i), r_rd, vecs[i].rd);
      chk($sformatf("vec%0d_fault", i), 32'(r_flt), 32'(vecs[i].flt));
      chk($sformatf("vec%0d_misaligned", i), 32'(r_mis), 32'(vecs[i].mis));
      chk($sformatf("vec%0d_write_count", i), 32'(r_nwr), 32'(vecs[i].nwr));
      chk($sformatf("vec%0d_read_count", i), 32'(r_nrd), 32'(vecs[i].nrd));
      chk($sformatf("vec%0d_write_cycle", i), 32'(r_wrc), 32'(vecs[i].wrc));
      if (vecs[i].cw) chk($sformatf("vec%0d_mem_word", i), tmem[vecs[i].addr[15:2]], vecs[i].word);
    end

    // Fault request with req_valid held high: second accept at T+3.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b011; req_addr = 32'h100;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      #1;
      rr[k] = int'(req_ready); rv[k] = int'(resp_valid); fl[k] = int'(resp_fault);
      if (k == 4) req_valid = 1'b0;
    end
    $display("held_valid ready=%0d%0d%0d%0d%0d%0d valid=%0d%0d%0d%0d%0d%0d",
             rr[1], rr[2], rr[3], rr[4], rr[5], rr[6], rv[1], rv[2], rv[3], rv[4], rv[5], rv[6]);
    chk("held_ready_t1", 32'(rr[1]), 32'h0);
    chk("held_ready_t2", 32'(rr[2]), 32'h0);
    chk("held_resp_t2", 32'(rv[2]), 32'h1);
    chk("held_fault_t2", 32'(fl[2]), 32'h1);
    chk("held_ready_t3", 32'(rr[3]), 32'h1);
    chk("held_resp_pulse_t3", 32'(rv[3]), 32'h0);
    chk("held_ready_t4", 32'(rr[4]), 32'h0);
    chk("held_second_resp_t5", 32'(rv[5]), 32'h1);
    chk("held_ready_t6", 32'(rr[6]), 32'h1);

    // Reset during the WRITE cycle of an SB must suppress the write.
    preload(14'h80, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h200; req_wdata = 32'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("sbrst_access_read", 32'(mem_read), 32'h1);
    @(negedge clk);
    chk("sbrst_write_before_reset", 32'(mem_write), 32'h1);
    reset = 1'b1;
    #1;
    chk("sbrst_write_gated", 32'(mem_write), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    $display("sb_reset ready=%0b valid=%0b addr=%h din=%h word=%h",
             req_ready, resp_valid, mem_addr, mem_din, tmem[14'h80]);
    chk("sbrst_mem_word", tmem[14'h80], 32'hCAFEF00D);
    chk("sbrst_req_ready", 32'(req_ready), 32'h1);
    chk("sbrst_resp_valid", 32'(resp_valid), 32'h0);
    chk("sbrst_resp_fault", 32'(resp_fault), 32'h0);
    chk("sbrst_mem_read", 32'(mem_read), 32'h0);
    chk("sbrst_mem_write", 32'(mem_write), 32'h0);
    chk("sbrst_mem_addr", mem_addr, 32'h0);
    chk("sbrst_mem_din", mem_din, 32'h0);

    run_req(1'b0, 3'b010, 32'h200, 32'h0);
    $display("post_reset LW 200 -> lat=%0d rdata=%h", r_lat, r_rd);
    chk("post_reset_latency", 32'(r_lat), 32'h2);
    chk("post_reset_rdata", r_rd, 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
